vga_agc_ctrl: RTL and testbench

VGA_AGC_CTRL -- requirements
Module: vga_agc_ctrl

---
 rtl/vga_agc_pkg.sv | 36 +++
 rtl/vga_agc_peak.sv | 24 ++
 rtl/vga_agc_ctrl.sv | 155 +++++++++++++++
 tb/tb_vga_agc_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_agc_pkg.sv
// Shared types and helpers for the VGA automatic gain control loop:
// FSM state encoding, derived code/window constants and the saturating code step.
package vga_agc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_SETTLE
    } agc_state_t;

    localparam int DEF_CODE_W   = 4;
    localparam int DEF_WIN_LOG2 = 5;

    function automatic int codeMaxOf(input int codeW);
        return (1 << codeW) - 1;
    endfunction

    function automatic int winLenOf(input int winLog2);
        return 1 << winLog2;
    endfunction

    localparam int CODE_MAX = codeMaxOf(DEF_CODE_W);
    localparam int WIN_LEN  = winLenOf(DEF_WIN_LOG2);

    // A pending decrement always wins over an increment; both ends saturate.
    function automatic int satStep(input int curCode, input logic dec, input logic inc,
                                   input int codeMax);
        if (dec)
            return (curCode > 0) ? curCode - 1 : 0;
        if (inc)
            return (curCode < codeMax) ? curCode + 1 : codeMax;
        return curCode;
    endfunction

endpackage

// File: rtl/vga_agc_peak.sv
// Per-channel running peak detector used by the AGC window measurement.
module vga_agc_peak #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_sampleEn,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_peak
);

    logic [DATA_W-1:0] r_peak;

    always_ff @(posedge clock) begin
        if (reset || i_clear)
            r_peak <= '0;
        else if (i_sampleEn && (i_sample > r_peak))
            r_peak <= i_sample;
    end

    assign o_peak = r_peak;

endmodule

// File: rtl/vga_agc_ctrl.sv
// Closed-loop VGA gain controller: windowed peak measurement, per-channel code step, settle hold.
// Optional lock detector enabled by defining VGA_AGC_LOCK_DET_EN.
module vga_agc_ctrl
    import vga_agc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CODE_W     = 4,
    parameter int DATA_W     = 8,
    parameter int WIN_LOG2   = 5,
    parameter int SETTLE_CYC = 8,
    parameter int INIT_CODE  = 8,
    parameter int LOCK_WINS  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     agc_en,
    input  logic [NUM_CH*CODE_W-1:0] manual_code,
    input  logic [DATA_W-1:0]        hi_thresh,
    input  logic [DATA_W-1:0]        lo_thresh,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH*CODE_W-1:0] code,
    output logic                     code_upd,
    output logic                     busy,
    output logic                     locked
);

    localparam int                  CODE_MAX_L = codeMaxOf(CODE_W);
    localparam logic [WIN_LOG2-1:0] WIN_LAST   = WIN_LOG2'(winLenOf(WIN_LOG2) - 1);
    localparam int                  SET_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]    SET_LAST   = SET_W'(SETTLE_CYC - 1);

    agc_state_t                r_state;
    logic [WIN_LOG2-1:0]       r_winCnt;
    logic [SET_W-1:0]          r_setCnt;
    logic [NUM_CH*CODE_W-1:0]  r_code;
    logic                      r_codeUpd;
    logic                      r_busy;

    logic [DATA_W-1:0]         w_peak [NUM_CH];
    logic                      w_peakClr;
    logic                      w_sampleEn;
    logic [NUM_CH*CODE_W-1:0]  w_nextCode;
    logic                      w_changed;
    int                        w_stepped;

    // Peaks are flushed whenever a window is abandoned or has just been judged.
    assign w_peakClr  = !agc_en || (r_state == ST_IDLE) || (r_state == ST_DECIDE);
    assign w_sampleEn = agc_en && (r_state == ST_MEASURE) && in_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_peak
        vga_agc_peak #(.DATA_W(DATA_W)) u_peak (
            .clock      (clock),
            .reset      (reset),
            .i_clear    (w_peakClr),
            .i_sampleEn (w_sampleEn),
            .i_sample   (in_data[k*DATA_W +: DATA_W]),
            .o_peak     (w_peak[k])
        );
    end

    always_comb begin
        w_nextCode = r_code;
        w_changed  = 1'b0;
        w_stepped  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_stepped = satStep(int'(r_code[k*CODE_W +: CODE_W]), w_peak[k] > hi_thresh,
                                w_peak[k] < lo_thresh, CODE_MAX_L);
            w_nextCode[k*CODE_W +: CODE_W] = w_stepped[CODE_W-1:0];
            if (w_nextCode[k*CODE_W +: CODE_W] != r_code[k*CODE_W +: CODE_W])
                w_changed = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_code    <= {NUM_CH{CODE_W'(INIT_CODE)}};
            r_winCnt  <= '0;
            r_setCnt  <= '0;
            r_codeUpd <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_codeUpd <= 1'b0;
            if (!agc_en) begin
                if (r_state == ST_IDLE)
                    r_code <= manual_code;
                r_state  <= ST_IDLE;
                r_winCnt <= '0;
                r_setCnt <= '0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_MEASURE;
                        r_winCnt <= '0;
                    end
                    ST_MEASURE: begin
                        if (in_valid) begin
                            r_winCnt <= r_winCnt + 1'b1;
                            if (r_winCnt == WIN_LAST)
                                r_state <= ST_DECIDE;
                        end
                    end
                    ST_DECIDE: begin
                        r_code    <= w_nextCode;
                        r_codeUpd <= w_changed;
                        r_busy    <= w_changed;
                        r_winCnt  <= '0;
                        r_setCnt  <= '0;
                        r_state   <= w_changed ? ST_SETTLE : ST_MEASURE;
                    end
                    ST_SETTLE: begin
                        if (r_setCnt == SET_LAST) begin
                            r_setCnt <= '0;
                            r_busy   <= 1'b0;
                            r_state  <= ST_MEASURE;
                        end else begin
                            r_setCnt <= r_setCnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign code     = r_code;
    assign code_upd = r_codeUpd;
    assign busy     = r_busy;

`ifdef VGA_AGC_LOCK_DET_EN
    localparam int LOCK_W = $clog2(LOCK_WINS + 1);

    logic [LOCK_W-1:0] r_lockCnt;

    // Counts consecutive windows that left every code untouched, saturating at LOCK_WINS.
    always_ff @(posedge clock) begin
        if (reset || !agc_en || (r_state == ST_IDLE))
            r_lockCnt <= '0;
        else if (r_state == ST_DECIDE) begin
            if (w_changed)
                r_lockCnt <= '0;
            else if (r_lockCnt != LOCK_W'(LOCK_WINS))
                r_lockCnt <= r_lockCnt + 1'b1;
        end
    end

    assign locked = (r_lockCnt >= LOCK_W'(LOCK_WINS));
`else
    // No lock detector in this build, so locked is permanently low.
    assign locked = (LOCK_WINS < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_vga_agc_ctrl.sv
// Self-checking bench for vga_agc_ctrl: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the AGC loop.
module tb_vga_agc_ctrl;

    localparam int WIN      = 4;
    localparam int SETTLE   = 3;
    localparam int INIT     = 8;
    localparam int LOCKWINS = 4;
    localparam int CMAX     = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        agc_en;
    logic [7:0]  manual_code;
    logic [7:0]  hi_thresh;
    logic [7:0]  lo_thresh;
    logic        in_valid;
    logic [15:0] in_data;
    logic [7:0]  code;
    logic        code_upd;
    logic        busy;
    logic        locked;

    int checks   = 0;
    int failures = 0;
    int updSeen  = 0;
    int busySeen = 0;

    // Behavioural model: which phase of the loop we are in, plus the samples of the open window.
    typedef enum int {M_IDLE, M_MEAS, M_DEC, M_SET} mode_t;
    bit    mValid = 1'b0;
    mode_t mMode;
    int    mCode[2];
    bit    mUpd;
    int    mSettleLeft;
    int    mLock;
    int    mQ0[$];
    int    mQ1[$];

    vga_agc_ctrl #(
        .NUM_CH(2), .CODE_W(4), .DATA_W(8), .WIN_LOG2(2),
        .SETTLE_CYC(SETTLE), .INIT_CODE(INIT), .LOCK_WINS(LOCKWINS)
    ) dut (
        .clock(clock), .reset(reset), .agc_en(agc_en), .manual_code(manual_code),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .in_valid(in_valid),
        .in_data(in_data), .code(code), .code_upd(code_upd), .busy(busy), .locked(locked)
    );

    always #5 clock = ~clock;

    function automatic int peakOf(input int q[$]);
        int m = 0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep();
        bit changed;
        int pk;
        int nc;
        if (reset) begin
            mValid = 1'b1;
            mMode = M_IDLE;
            mCode[0] = INIT;
            mCode[1] = INIT;
            mUpd = 1'b0;
            mLock = 0;
            mSettleLeft = 0;
            mQ0.delete();
            mQ1.delete();
            return;
        end
        if (!mValid) return;
        mUpd = 1'b0;
        if (!agc_en) begin
            if (mMode == M_IDLE) begin
                mCode[0] = int'(manual_code[3:0]);
                mCode[1] = int'(manual_code[7:4]);
            end
            mMode = M_IDLE;
            mLock = 0;
            mQ0.delete();
            mQ1.delete();
            return;
        end
        case (mMode)
            M_IDLE: begin
                mMode = M_MEAS;
                mLock = 0;
            end
            M_MEAS: if (in_valid) begin
                mQ0.push_back(int'(in_data[7:0]));
                mQ1.push_back(int'(in_data[15:8]));
                if (mQ0.size() == WIN) mMode = M_DEC;
            end
            M_DEC: begin
                changed = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    pk = (k == 0) ? peakOf(mQ0) : peakOf(mQ1);
                    nc = mCode[k];
                    if (pk > int'(hi_thresh)) nc = (nc == 0) ? 0 : nc - 1;
                    else if (pk < int'(lo_thresh)) nc = (nc == CMAX) ? CMAX : nc + 1;
                    if (nc != mCode[k]) changed = 1'b1;
                    mCode[k] = nc;
                end
                mUpd = changed;
                if (changed) mLock = 0;
                else if (mLock < LOCKWINS) mLock++;
                mMode = changed ? M_SET : M_MEAS;
                mSettleLeft = SETTLE;
                mQ0.delete();
                mQ1.delete();
            end
            M_SET: begin
                mSettleLeft--;
                if (mSettleLeft == 0) mMode = M_MEAS;
            end
            default: mMode = M_IDLE;
        endcase
    endtask

    task automatic compareModel();
        int expLocked;
        if (!mValid) return;
`ifdef VGA_AGC_LOCK_DET_EN
        expLocked = (mLock >= LOCKWINS) ? 1 : 0;
`else
        expLocked = 0;
`endif
        checkOutput("model_code", int'(code), (mCode[1] << 4) | mCode[0]);
        checkOutput("model_code_upd", int'(code_upd), int'(mUpd));
        checkOutput("model_busy", int'(busy), (mMode == M_SET) ? 1 : 0);
        checkOutput("model_locked", int'(locked), expLocked);
        if (code_upd === 1'b1) updSeen++;
        if (busy === 1'b1) busySeen++;
    endtask

    // One clock: drive inputs, let the model and DUT take the edge, compare on the falling edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d0, input logic [7:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
        @(posedge clock);
        modelStep();
        @(negedge clock);
        compareModel();
    endtask

    task automatic runWindow(input logic [7:0] d0, input logic [7:0] d1);
        repeat (WIN) applyStimulus(1'b1, d0, d1);
        repeat (6) applyStimulus(1'b0, 8'd0, 8'd0);
    endtask

    task automatic setManual(input logic [3:0] m0, input logic [3:0] m1);
        agc_en = 1'b0;
        manual_code = {m1, m0};
        repeat (2) applyStimulus(1'b0, 8'd0, 8'd0);
        agc_en = 1'b1;
        applyStimulus(1'b0, 8'd0, 8'd0);
    endtask

    task automatic clearSeen();
        updSeen  = 0;
        busySeen = 0;
    endtask

    initial begin
        int level;
        int expLock;
`ifdef VGA_AGC_LOCK_DET_EN
        expLock = 1;
`else
        expLock = 0;
`endif
        reset = 1'b1; agc_en = 1'b1; manual_code = 8'h00;
        hi_thresh = 8'd200; lo_thresh = 8'd50; in_valid = 1'b0; in_data = 16'h0;
        @(negedge clock);
        repeat (3) applyStimulus(1'b0, 8'd0, 8'd0);
        checkOutput("reset_code", int'(code), 'h88);
        checkOutput("reset_code_upd", int'(code_upd), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_locked", int'(locked), 0);
        reset = 1'b0;

        clearSeen();
        applyStimulus(1'b0, 8'd0, 8'd0);
        runWindow(8'd250, 8'd100);
        checkOutput("first_window_code", int'(code), 'h87);
        checkOutput("first_window_upd_cycles", updSeen, 1);
        checkOutput("first_window_busy_cycles", busySeen, 3);

        setManual(4'd14, 4'd14);
        checkOutput("manual_14_code", int'(code), 'hEE);
        clearSeen();
        runWindow(8'd10, 8'd10);
        checkOutput("inc_to_max_code", int'(code), 'hFF);
        checkOutput("inc_to_max_upd", updSeen, 1);
        clearSeen();
        runWindow(8'd10, 8'd10);
        checkOutput("saturated_code", int'(code), 'hFF);
        checkOutput("saturated_upd", updSeen, 0);
        checkOutput("saturated_busy", busySeen, 0);

        setManual(4'd8, 4'd8);
        clearSeen();
        runWindow(8'd200, 8'd50);
        checkOutput("equal_thresh_code", int'(code), 'h88);
        checkOutput("equal_thresh_upd", updSeen, 0);
        lo_thresh = 8'd210;
        runWindow(8'd205, 8'd205);
        checkOutput("dec_wins_code", int'(code), 'h77);
        lo_thresh = 8'd50;

        clearSeen();
        manual_code = {4'd5, 4'd3};
        repeat (2) applyStimulus(1'b1, 8'd120, 8'd120);
        agc_en = 1'b0;
        repeat (2) applyStimulus(1'b0, 8'd0, 8'd0);
        checkOutput("abort_manual_code", int'(code), 'h53);
        checkOutput("abort_upd", updSeen, 0);

        setManual(4'd8, 4'd8);
        clearSeen();
        repeat (WIN) applyStimulus(1'b1, 8'd250, 8'd250);
        repeat (1 + SETTLE) applyStimulus(1'b1, 8'd255, 8'd255);
        repeat (WIN) applyStimulus(1'b1, 8'd100, 8'd100);
        repeat (6) applyStimulus(1'b0, 8'd0, 8'd0);
        checkOutput("settle_ignore_code", int'(code), 'h77);
        checkOutput("settle_ignore_upd", updSeen, 1);
        checkOutput("settle_ignore_busy", busySeen, 3);

        repeat (3) runWindow(8'd100, 8'd100);
        checkOutput("lock_after_4_windows", int'(locked), expLock);
        runWindow(8'd250, 8'd250);
        checkOutput("lock_cleared_code", int'(code), 'h66);
        checkOutput("lock_cleared", int'(locked), 0);

        level = 150;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (agc_en) begin
                if ($urandom_range(0, 249) == 0) agc_en = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                agc_en = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                hi_thresh = 8'($urandom_range(120, 230));
                lo_thresh = 8'($urandom_range(20, 140));
            end
            if ($urandom_range(0, 49) == 0) manual_code = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) level = ($urandom_range(0, 2) == 0) ? 60 :
                                                    (($urandom_range(0, 1) == 0) ? 150 : 255);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, level)),
                          8'($urandom_range(0, level)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
